// File: rtl/x_micro_sequencer_ctrl.sv
// x_micro_sequencer_ctrl: executes a micro-sequencer program from RAM (output, wait, jump, loop, halt)
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_start        start request, honoured only when idle
//   i_abort        stop execution and return to idle
//   o_busy         high while a program is running
//   o_raddr        program RAM read address (the program counter)
//   i_rdata        {data, cmd} word, valid one cycle after o_raddr
//   o_data         last word emitted by an OUT command
//   o_valid        one-cycle pulse when o_data is updated
//   o_done         one-cycle pulse when a HALT retires
module x_micro_sequencer_ctrl #(
    parameter int AW = 9,
    parameter int DW = 36,
    parameter int CW = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_busy,
    output logic [AW-1:0]      o_raddr,
    input  logic [DW+CW-1:0]   i_rdata,
    output logic [DW-1:0]      o_data,
    output logic               o_valid,
    output logic               o_done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [CW-1:0] CMD_OUT  = CW'(1);
    localparam logic [CW-1:0] CMD_WAIT = CW'(2);
    localparam logic [CW-1:0] CMD_JUMP = CW'(3);
    localparam logic [CW-1:0] CMD_LOOP = CW'(4);
    localparam logic [CW-1:0] CMD_HALT = CW'(15);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          lactive_q, lactive_d;
    logic [15:0]   lcnt_q, lcnt_d;
    logic [15:0]   wcnt_q, wcnt_d;

    logic [CW-1:0] cmd;
    logic [DW-1:0] dat;
    logic [15:0]   wait_cnt;
    logic [15:0]   loop_cnt;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;

    assign cmd      = i_rdata[CW-1:0];
    assign dat      = i_rdata[DW+CW-1:CW];
    assign wait_cnt = dat[15:0];
    assign loop_cnt = dat[AW+15:AW];
    assign target   = dat[AW-1:0];
    assign pc_inc   = pc_q + AW'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        lactive_d = lactive_q;
        lcnt_d    = lcnt_q;
        wcnt_d    = wcnt_q;
        if (i_abort) begin
            // abort beats everything in flight, including an OUT or HALT being decoded
            state_d   = ST_IDLE;
            lactive_d = 1'b0;
            wcnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                    end
                end
                ST_FETCH: state_d = ST_EXEC;
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                    case (cmd)
                        CMD_OUT: begin
                            data_d  = dat;
                            valid_d = 1'b1;
                        end
                        CMD_WAIT: begin
                            if (wait_cnt != 16'd0) begin
                                state_d = ST_WAIT;
                                pc_d    = pc_q;
                                wcnt_d  = wait_cnt - 16'd1;
                            end
                        end
                        CMD_JUMP: pc_d = target;
                        CMD_LOOP: begin
                            // a single shared counter: first visit arms it, later visits count it down
                            if (!lactive_q) begin
                                if (loop_cnt != 16'd0) begin
                                    lactive_d = 1'b1;
                                    lcnt_d    = loop_cnt - 16'd1;
                                    pc_d      = target;
                                end
                            end else if (lcnt_q == 16'd0) begin
                                lactive_d = 1'b0;
                            end else begin
                                lcnt_d = lcnt_q - 16'd1;
                                pc_d   = target;
                            end
                        end
                        CMD_HALT: begin
                            state_d   = ST_IDLE;
                            pc_d      = pc_q;
                            done_d    = 1'b1;
                            lactive_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT: begin
                    if (wcnt_q == 16'd0) begin
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
                    end else begin
                        wcnt_d = wcnt_q - 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            lactive_q <= 1'b0;
            lcnt_q    <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= (state_d != ST_IDLE);
            lactive_q <= lactive_d;
            lcnt_q    <= lcnt_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_raddr = pc_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_done  = done_q;
endmodule

// File: tb/tb_x_micro_sequencer_ctrl.sv
// tb_x_micro_sequencer_ctrl: scoreboard bench driving directed and random programs through the sequencer
module tb_x_micro_sequencer_ctrl;
    logic        clk = 1'b0;
    logic        i_rst, i_start, i_abort;
    logic        o_busy, o_valid, o_done;
    logic [8:0]  o_raddr;
    logic [39:0] rdata;
    logic [35:0] o_data;
    logic [39:0] mem [0:511];

    typedef struct {int cyc; bit done; logic [35:0] data;} ev_t;
    typedef struct {int cyc; logic [8:0] pc;} fe_t;
    ev_t plan[$];
    ev_t sb[$];
    fe_t fq[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_od;

    x_micro_sequencer_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .o_busy(o_busy), .o_raddr(o_raddr), .i_rdata(rdata),
        .o_data(o_data), .o_valid(o_valid), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdata <= mem[o_raddr];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic ev_chk(input bit is_done);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s cycle %0d got data %0h expected no event", is_done ? "done" : "valid", cyc, o_data);
        end else begin
            e = sb.pop_front();
            if (e.done != is_done || e.cyc != cyc || e.data !== o_data) begin
                errors++;
                $display("FAIL event got done=%0b cycle %0d data %0h expected done=%0b cycle %0d data %0h",
                         is_done, cyc, o_data, e.done, e.cyc, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) ev_chk(1'b0);
        if (o_done) ev_chk(1'b1);
    end

    function automatic logic [35:0] rnd36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    function automatic logic [39:0] ins(input logic [3:0] c, input logic [35:0] d);
        return {d, c};
    endfunction

    function automatic logic [39:0] loop_ins(input logic [8:0] tgt, input logic [15:0] n);
        logic [35:0] d;
        d = rnd36();
        d[24:0] = {n, tgt};
        return ins(4'd4, d);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = ins(4'hF, rnd36());
    endtask

    // Instruction-level interpreter: each instruction is fetched at cycle f, decoded at f+1,
    // and its effects (OUT data, HALT done) are seen at f+2; WAIT C delays the next fetch by C.
    task automatic model_run(input int t0, input logic [35:0] od0, output int dcyc, output logic [35:0] od);
        logic [8:0]  pc = '0;
        bit          lact = 1'b0;
        logic [15:0] lcnt = '0;
        int          f = t0 + 1;
        logic [35:0] d;
        plan.delete();
        fq.delete();
        od = od0;
        dcyc = t0 + 100000;
        for (int s = 0; s < 10000; s++) begin
            d = mem[pc][39:4];
            fq.push_back('{cyc: f, pc: pc});
            case (mem[pc][3:0])
                4'd1: begin
                    od = d;
                    plan.push_back('{cyc: f + 2, done: 1'b0, data: d});
                    pc++;
                    f += 2;
                end
                4'd2: begin
                    f += 2 + int'(d[15:0]);
                    pc++;
                end
                4'd3: begin
                    pc = d[8:0];
                    f += 2;
                end
                4'd4: begin
                    if (!lact && d[24:9] != 16'd0) begin
                        lact = 1'b1;
                        lcnt = d[24:9] - 16'd1;
                        pc = d[8:0];
                    end else if (lact && lcnt != 16'd0) begin
                        lcnt--;
                        pc = d[8:0];
                    end else begin
                        lact = 1'b0;
                        pc++;
                    end
                    f += 2;
                end
                4'd15: begin
                    plan.push_back('{cyc: f + 2, done: 1'b1, data: od});
                    dcyc = f + 2;
                    return;
                end
                default: begin
                    pc++;
                    f += 2;
                end
            endcase
        end
    endtask

    // Runs the program in mem from a start pulse. poke: cycle offset of a stray start while busy.
    // stop: cycle offset at which abort (or reset when use_rst) is applied.
    task automatic run(input int poke, input int stop, input bit use_rst);
        int t0, dcyc, a;
        logic [35:0] fin, od_a;
        @(negedge clk);
        t0 = cyc;
        model_run(t0, exp_od, dcyc, fin);
        if (t0 + poke >= dcyc) poke = 0;
        if (t0 + stop > dcyc) stop = 0;
        foreach (plan[i]) sb.push_back(plan[i]);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        while (cyc <= dcyc && cyc < t0 + 20000 && !(stop != 0 && cyc == t0 + stop)) begin
            while (fq.size() != 0 && fq[0].cyc == cyc) begin
                chk("fetch_raddr", o_raddr, fq[0].pc);
                void'(fq.pop_front());
            end
            i_start = (poke != 0 && cyc == t0 + poke);
            @(negedge clk);
        end
        i_start = 1'b0;
        if (stop != 0 && cyc == t0 + stop) begin
            a = cyc;
            od_a = exp_od;
            foreach (plan[i]) if (plan[i].cyc <= a && !plan[i].done) od_a = plan[i].data;
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > a) sb.delete(i);
            if (use_rst) i_rst = 1'b1; else i_abort = 1'b1;
            @(negedge clk);
            i_rst = 1'b0;
            i_abort = 1'b0;
            exp_od = use_rst ? 36'd0 : od_a;
            chk("stop_busy", o_busy, 0);
            chk("stop_valid", o_valid, 0);
            chk("stop_done", o_done, 0);
            chk("stop_data", o_data, exp_od);
            if (use_rst) chk("rst_raddr", o_raddr, 0);
            repeat (3) @(negedge clk);
        end else begin
            exp_od = fin;
        end
        chk("drain", sb.size(), 0);
        chk("idle_busy", o_busy, 0);
        fq.delete();
    endtask

    task automatic random_prog();
        int len, loop_at;
        logic [35:0] d;
        clear_mem();
        len = $urandom_range(2, 8);
        loop_at = $urandom_range(0, 1) ? len - 1 : -1;
        for (int i = 0; i < len; i++) begin
            d = rnd36();
            if (i == loop_at) begin
                mem[i] = loop_ins(9'($urandom_range(0, i)), 16'($urandom_range(0, 3)));
            end else begin
                case ($urandom_range(0, 5))
                    0, 5: mem[i] = ins(4'd1, d);
                    1: mem[i] = ins(4'd0, d);
                    2: begin
                        d[15:0] = 16'($urandom_range(0, 5));
                        mem[i] = ins(4'd2, d);
                    end
                    3: begin
                        d[8:0] = 9'($urandom_range(i + 1, len));
                        mem[i] = ins(4'd3, d);
                    end
                    default: mem[i] = ins(4'($urandom_range(5, 14)), d);
                endcase
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        exp_od = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_raddr", o_raddr, 0);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;

        // start together with abort in idle must stay idle
        @(negedge clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_abort_idle", o_busy, 0);

        mem[0] = ins(4'd1, 36'hA5);
        mem[1] = ins(4'd1, 36'h3C);
        mem[2] = ins(4'hF, 36'd0);
        run(0, 0, 0);

        clear_mem();
        mem[0] = ins(4'd2, 36'd5);
        mem[1] = ins(4'd1, 36'd1);
        run(0, 0, 0);
        mem[0] = ins(4'd2, 36'h123450000);
        run(0, 0, 0);

        clear_mem();
        mem[0] = ins(4'd1, 36'd7);
        mem[1] = loop_ins(9'd0, 16'd3);
        run(0, 0, 0);
        run(0, 0, 0);
        run(4, 0, 0);
        run(0, 6, 1);
        run(0, 0, 0);

        clear_mem();
        mem[0]   = loop_ins(9'd2, 16'd1);
        mem[2]   = ins(4'd3, 36'hFFFFFF1FF);
        mem[511] = ins(4'd1, 36'd9);
        run(0, 0, 0);

        clear_mem();
        mem[0] = ins(4'd2, 36'd100);
        mem[1] = ins(4'd1, 36'h55);
        run(0, 20, 0);
        run(0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            random_prog();
            run($urandom_range(0, 1) ? $urandom_range(2, 30) : 0,
                $urandom_range(0, 3) == 0 ? $urandom_range(1, 40) : 0,
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/x_micro_sequencer_ctrl.md
# x_micro_sequencer_ctrl

Execution engine for the micro-sequencer program RAM. The program RAM holds 40-bit words of {data[35:0], cmd[3:0]}. On `i_start` this block walks the RAM from address 0 and decodes each command: output, wait, jump, counted loop, halt. It drives a registered 36-bit output word with a valid strobe and reports busy/done. It sits between the program RAM read port and the downstream consumer of `o_data`; the RAM write port stays outside this block.

## Interface
- `AW`, default 9: program RAM address width.
- `DW`, default 36: data field width.
- `CW`, default 4: command field width.
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_abort`  in  1  stop execution; return to IDLE next cycle.
- `o_busy`  out  1  high while not IDLE.
- `o_raddr`  out  AW  program RAM read address (registered PC).
- `i_rdata`  in  DW+CW  {data, cmd}; valid one cycle after `o_raddr` is presented.
- `o_data`  out  DW  registered output word.
- `o_valid`  out  1  one-cycle pulse when `o_data` is updated.
- `o_done`  out  1  one-cycle pulse on HALT.

## Operation
- States: IDLE, FETCH, EXEC, WAIT.
  - IDLE: `i_start` → FETCH with pc=0.
  - FETCH → EXEC unconditionally; the RAM samples `o_raddr`=pc.
  - EXEC decodes `i_rdata`.
- Commands (cmd). "Advance" = pc+1 → FETCH.
  - 0 NOP: advance.
  - 1 OUT: `o_data`←data; `o_valid` pulses for one cycle; advance.
  - 2 WAIT: let C = data[15:0].
    - C==0: advance.
    - Otherwise: wcnt←C-1 → WAIT. In WAIT, when wcnt==0 advance; otherwise wcnt decrements.
  - 3 JUMP: pc←data[AW-1:0] → FETCH.
  - 4 LOOP: target = data[AW-1:0], N = data[AW+15:AW]. One non-nesting loop counter (lactive, lcnt).
    - lactive=0, N==0: advance.
    - lactive=0, N>0: lcnt←N-1, lactive←1, pc←target.
    - lactive=1, lcnt==0: lactive←0, advance.
    - lactive=1, lcnt>0: lcnt decrements, pc←target.
    - Net effect: the body executes N+1 times in total.
  - 15 HALT: `o_done` pulses; → IDLE; lactive←0.
  - 5-14: treated as NOP.
- pc arithmetic is modulo 2^AW; pc+1 from 2^AW-1 wraps to 0.
- Priority, highest first: `i_rst`, `i_abort`, normal operation.
- Abort:
  - Any state → IDLE.
  - lactive and wcnt cleared.
  - `o_data` retains its value.
  - No `o_done`.
  - Any OUT in the same cycle is suppressed.
- `i_start` while busy is ignored. `i_start` together with `i_abort` in IDLE stays in IDLE.
- Writing the program RAM while `o_busy`=1 is disallowed; results are undefined.

## Timing
- Reset values:
  - Outputs: `o_busy`=0, `o_raddr`=0, `o_data`=0, `o_valid`=0, `o_done`=0.
  - Internal: state IDLE, lactive=0, lcnt=0, wcnt=0.
- All outputs are registered.
- `i_start` high in IDLE at cycle T:
  - T+1: `o_busy`=1, FETCH, `o_raddr`=0.
  - T+2: EXEC.
- Each instruction costs 2 cycles (FETCH+EXEC). WAIT with C>0 costs 2+C cycles.
- OUT decoded in EXEC at cycle E: `o_data`/`o_valid` visible at E+1, together with the next FETCH.
- HALT decoded at E:
  - E+1: `o_done`=1 and `o_busy`=0.
  - A new `i_start` is accepted from E+1.
- `i_abort` at cycle A: `o_busy`=0 at A+1.
- `i_rst` mid-operation: all reset values hold at the next edge, regardless of state.

## Test plan
- Program {OUT 0xA5, OUT 0x3C, HALT}, `i_start` at T:
  - `o_valid` at T+3 and T+5 with `o_data`=0xA5 then 0x3C.
  - `o_done` at T+7, `o_busy` low at T+7.
- Program {WAIT 5, OUT 1, HALT}: OUT `o_valid` at T+10; WAIT 0 variant gives `o_valid` at T+5.
- Program {OUT 7 at addr 0, LOOP target=0 N=3 at addr 1, HALT}: exactly 4 `o_valid` pulses, then `o_done`. Second run after `o_done` gives 4 pulses again (lactive cleared).
- Program with JUMP to 511 and OUT 9 at 511: pc wraps to 0 after 511; observe `o_raddr` sequence …, 511, 0.
- `i_abort` during WAIT 100 at cycle A:
  - `o_busy`=0 at A+1, no `o_done`, `o_data` unchanged.
  - A subsequent `i_start` restarts at address 0.
- `i_start` pulsed while busy: no restart (`o_raddr` sequence unaffected). `i_rst` asserted mid-LOOP: all outputs 0 next cycle; rerun gives the full loop count.
